reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_STAGES, default 3: number of staged reset outputs, range 1..8.
REQ-002 Parameter STRETCH, default 16: cycles all stages are held in reset after the last request, range 2..255.
REQ-003 Parameter GAP, default 4: cycles between consecutive stage releases, range 1..255.
REQ-004 Parameter DEBOUNCE, default 8: cycles btn_n must be stably low to count as a request, range 2..255.
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 nrst  input  1  reset, asynchronous and active-low; assertion is asynchronous, deassertion is already synchronous to clk.
REQ-007 sw_rst_req  input  1  software reset request, one-cycle pulse, synchronous.
REQ-008 wdt_expire  input  1  watchdog expiry, one-cycle pulse, synchronous.
REQ-009 btn_n  input  1  raw external reset button, asynchronous, active-low.
REQ-010 cause_clr  input  1  clears rst_cause to POR, synchronous.
REQ-011 stage_rst_n  output  N_STAGES  staged active-low resets; bit 0 is released first.
REQ-012 busy  output  1  high while any stage_rst_n bit is low.
REQ-013 rst_cause  output  2  cause of the last sequence: 00 POR, 01 button, 10 software, 11 watchdog.

Function
REQ-014 The FSM SHALL have the states IDLE, ASSERT and RELEASE; all outputs SHALL be registered.
REQ-015 A request is sw_rst_req, wdt_expire or btn_req sampled high on an edge; btn_req comes from the button path (REQ-030).
REQ-016 A request sampled on edge E SHALL drive all stage_rst_n bits to 0 and busy to 1 from edge E, enter ASSERT and clear the counter, from any state.
REQ-017 In ASSERT the counter SHALL increment each cycle; at count STRETCH-1 the state SHALL become RELEASE, bit 0 SHALL go to 1 and the counter SHALL clear.
REQ-018 In RELEASE, bit k SHALL go to 1 GAP cycles after bit k-1, and released bits SHALL stay at 1.
REQ-019 When the last bit is released, the state SHALL become IDLE on the same edge and busy SHALL fall on that edge.
REQ-020 A request in ASSERT SHALL restart the STRETCH count; a request in RELEASE SHALL re-assert all bits and restart from ASSERT.
REQ-021 On each accepted request, rst_cause SHALL load the highest-priority source: watchdog > software > button.
REQ-022 cause_clr SHALL set rst_cause to 00; a request on the same edge SHALL take precedence over cause_clr.
REQ-023 Counter width SHALL be 8 bits and the counter SHALL never wrap.
REQ-024 With N_STAGES=1, bit 0 SHALL release after STRETCH cycles and the block SHALL go directly to IDLE.

Reset
REQ-025 While nrst is low: stage_rst_n SHALL be all 0, busy SHALL be 1, the state SHALL be ASSERT, the counter SHALL be 0, rst_cause SHALL be 00, and the button synchronizer and debounce state SHALL be cleared.
REQ-026 After nrst rises, a full power-on sequence SHALL run per REQ-017..019.
REQ-027 nrst asserted mid-sequence SHALL take effect asynchronously and override any request in progress.

Configuration
REQ-028 Macro RSTSEQ_BTN_DEBOUNCE_EN SHALL enable the button path.
REQ-029 Without RSTSEQ_BTN_DEBOUNCE_EN, btn_n SHALL be ignored, btn_req SHALL be constant 0, and no synchronizer or debounce flops SHALL exist.
REQ-030 With RSTSEQ_BTN_DEBOUNCE_EN, btn_n SHALL pass through a 2-flop synchronizer; btn_req SHALL pulse for one cycle when the synchronized level has been low for DEBOUNCE consecutive cycles; it SHALL not re-pulse until btn_n is seen high again.

Verification (N_STAGES=3, STRETCH=16, GAP=4, DEBOUNCE=8)
REQ-031 nrst low 5 cycles then released -> bit 0 rises 16 cycles after release, bit 1 at +20, bit 2 at +24; busy falls with bit 2; rst_cause=00.
REQ-032 sw_rst_req pulse in IDLE -> stage_rst_n=000 from that edge; same release timing; rst_cause=10.
REQ-033 wdt_expire and sw_rst_req on the same edge -> rst_cause=11; a single sequence runs.
REQ-034 sw_rst_req 2 cycles after bit 0 releases -> stage_rst_n=000 on that edge; full 16/4/4 sequence restarts.
REQ-035 Macro defined: btn_n low 5 cycles -> no reset; btn_n low 12 cycles -> sequence starts 10 cycles after the fall with rst_cause=01; macro undefined: btn_n held low -> no reset.
REQ-036 nrst pulsed low during ASSERT after a watchdog request -> outputs immediately 000, rst_cause=00, power-on sequence follows.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all stage resets low after POR, software, watchdog or button
// requests, then releases them one at a time. Button path is enabled by RSTSEQ_BTN_DEBOUNCE_EN.
module reset_sequencer #(
  parameter int N_STAGES = 3,
  parameter int STRETCH  = 16,
  parameter int GAP      = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                sw_rst_req,
  input  logic                wdt_expire,
  input  logic                btn_n,
  input  logic                cause_clr,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                busy,
  output logic [1:0]          rst_cause
);

  // state   | meaning
  // IDLE    | every stage released, waiting for a request
  // ASSERT  | every stage held low, counting STRETCH cycles
  // RELEASE | stages released in order, one every GAP cycles

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] STRETCH_TC = 8'(STRETCH - 1);
  localparam logic [7:0] GAP_TC     = 8'(GAP - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_STAGES-1:0] stage_d, stage_shift;
  logic                busy_d;
  logic [1:0]          cause_d;
  logic                btn_req;
  logic                req;

`ifdef RSTSEQ_BTN_DEBOUNCE_EN
  localparam logic [7:0] DEB_TC = 8'(DEBOUNCE - 1);

  logic       btn_meta, btn_sync, btn_fired;
  logic [7:0] deb_cnt;

  // synchronizer resets to the released (high) level so reset never looks like a press
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      deb_cnt   <= 8'd0;
      btn_fired <= 1'b0;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
      if (btn_sync) begin
        deb_cnt   <= 8'd0;
        btn_fired <= 1'b0;
      end else if (deb_cnt != DEB_TC) begin
        deb_cnt <= deb_cnt + 8'd1;
      end else if (btn_req) begin
        btn_fired <= 1'b1;
      end
    end
  end

  assign btn_req = !btn_sync && (deb_cnt == DEB_TC) && !btn_fired;
`else
  localparam int unused_debounce = DEBOUNCE;
  logic unused_btn;
  assign unused_btn = btn_n;
  assign btn_req    = 1'b0;
`endif

  assign req = sw_rst_req | wdt_expire | btn_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_rst_n;
    cause_d     = rst_cause;
    stage_shift = '0;
    stage_shift[0] = 1'b1;
    for (int k = 1; k < N_STAGES; k++) begin
      stage_shift[k] = stage_rst_n[k-1];
    end

    if (req) begin
      state_d = ASSERT;
      cnt_d   = 8'd0;
      stage_d = '0;
    end else begin
      case (state_q)
        ASSERT, RELEASE: begin
          if (cnt_q == ((state_q == ASSERT) ? STRETCH_TC : GAP_TC)) begin
            stage_d = stage_shift;
            cnt_d   = 8'd0;
            state_d = (&stage_shift) ? IDLE : RELEASE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    if (wdt_expire)      cause_d = 2'b11;
    else if (sw_rst_req) cause_d = 2'b10;
    else if (btn_req)    cause_d = 2'b01;
    else if (cause_clr)  cause_d = 2'b00;

    busy_d = ~(&stage_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ASSERT;
      cnt_q       <= 8'd0;
      stage_rst_n <= '0;
      busy        <= 1'b1;
      rst_cause   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_rst_n <= stage_d;
      busy        <= busy_d;
      rst_cause   <= cause_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes expected output changes with their
// cycle numbers; a negedge monitor pops and compares whenever the outputs change.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_expire = 1'b0;
  logic       btn_n = 1'b1;
  logic       cause_clr = 1'b0;
  logic [2:0] stage_rst_n;
  logic       busy;
  logic [1:0] rst_cause;
  logic [0:0] stage1_rst_n;
  logic       busy1;
  logic [1:0] cause1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [5:0] val;
    string      name;
  } exp_t;
  exp_t exp_q[$];

  reset_sequencer #(.N_STAGES(3), .STRETCH(16), .GAP(4), .DEBOUNCE(8)) u_dut (
    .clk(clk), .nrst(nrst), .sw_rst_req(sw_rst_req), .wdt_expire(wdt_expire),
    .btn_n(btn_n), .cause_clr(cause_clr), .stage_rst_n(stage_rst_n), .busy(busy),
    .rst_cause(rst_cause)
  );

  reset_sequencer #(.N_STAGES(1), .STRETCH(2), .GAP(1), .DEBOUNCE(8)) u_dut1 (
    .clk(clk), .nrst(nrst), .sw_rst_req(sw_rst_req), .wdt_expire(wdt_expire),
    .btn_n(btn_n), .cause_clr(cause_clr), .stage_rst_n(stage1_rst_n), .busy(busy1),
    .rst_cause(cause1)
  );

  initial begin
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] st, input logic b, input logic [1:0] ca,
                      input string name);
    exp_t e;
    e.cyc  = c;
    e.val  = {st, b, ca};
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic seq_push(input int s, input logic [1:0] ca, input string name);
    push(s,      3'b000, 1'b1, ca, {name, "_assert"});
    push(s + 16, 3'b001, 1'b1, ca, {name, "_bit0"});
    push(s + 20, 3'b011, 1'b1, ca, {name, "_bit1"});
    push(s + 24, 3'b111, 1'b0, ca, {name, "_bit2"});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  task automatic pulse_at(input int c, input logic sw, input logic wdt, input logic clr);
    wait_to(c);
    sw_rst_req = sw;
    wdt_expire = wdt;
    cause_clr  = clr;
    @(posedge clk);
    #1;
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    cause_clr  = 1'b0;
  endtask

  logic [5:0] prev_val = 6'b000_1_00;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [5:0] cur;
      cur = {stage_rst_n, busy, rst_cause};
      if (cur !== prev_val) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%b expected=no change", cyc, cur);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            n_fail++;
            $display("FAIL %s got cyc=%0d val=%b expected cyc=%0d val=%b",
                     e.name, cyc, cur, e.cyc, e.val);
          end
        end
        prev_val = cur;
      end
    end
  end

  initial begin
    wait_to(3);
    check("reset_stage", {5'd0, stage_rst_n}, 8'b000);
    check("reset_busy", {7'd0, busy}, 8'd1);
    check("reset_cause", {6'd0, rst_cause}, 8'd0);
    check("reset_n1_stage", {7'd0, stage1_rst_n}, 8'd0);
    mon_en = 1'b1;

    // power-on sequence: nrst released after edge 5
    wait_to(5);
    nrst = 1'b1;
    push(21, 3'b001, 1'b1, 2'b00, "por_bit0");
    push(25, 3'b011, 1'b1, 2'b00, "por_bit1");
    push(29, 3'b111, 1'b0, 2'b00, "por_bit2");
    wait_to(6);
    check("n1_hold_stage", {7'd0, stage1_rst_n}, 8'd0);
    check("n1_hold_busy", {7'd0, busy1}, 8'd1);
    wait_to(7);
    check("n1_release_stage", {7'd0, stage1_rst_n}, 8'd1);
    check("n1_release_busy", {7'd0, busy1}, 8'd0);

    seq_push(41, 2'b10, "sw_idle");
    pulse_at(40, 1'b1, 1'b0, 1'b0);

    seq_push(81, 2'b11, "wdt_sw");
    pulse_at(80, 1'b1, 1'b1, 1'b0);

    push(111, 3'b111, 1'b0, 2'b00, "cause_clr");
    pulse_at(110, 1'b0, 1'b0, 1'b1);

    seq_push(121, 2'b10, "sw_over_clr");
    pulse_at(120, 1'b1, 1'b0, 1'b1);

    // request two cycles after bit 0 releases
    push(151, 3'b000, 1'b1, 2'b11, "rel_wdt_assert");
    push(167, 3'b001, 1'b1, 2'b11, "rel_wdt_bit0");
    seq_push(169, 2'b10, "rel_restart");
    pulse_at(150, 1'b0, 1'b1, 1'b0);
    pulse_at(168, 1'b1, 1'b0, 1'b0);

    // request during ASSERT restarts the stretch count
    push(201, 3'b000, 1'b1, 2'b11, "asr_wdt");
    seq_push(206, 2'b10, "asr_restart");
    pulse_at(200, 1'b0, 1'b1, 1'b0);
    pulse_at(205, 1'b1, 1'b0, 1'b0);

    // nrst pulse during ASSERT after a watchdog request
    push(241, 3'b000, 1'b1, 2'b11, "nrst_wdt");
    push(245, 3'b000, 1'b1, 2'b00, "nrst_async");
    push(264, 3'b001, 1'b1, 2'b00, "nrst_por_bit0");
    push(268, 3'b011, 1'b1, 2'b00, "nrst_por_bit1");
    push(272, 3'b111, 1'b0, 2'b00, "nrst_por_bit2");
    pulse_at(240, 1'b0, 1'b1, 1'b0);
    wait_to(245);
    nrst = 1'b0;
    #1;
    check("nrst_async_stage", {5'd0, stage_rst_n}, 8'b000);
    check("nrst_async_cause", {6'd0, rst_cause}, 8'd0);
    wait_to(248);
    nrst = 1'b1;

`ifdef RSTSEQ_BTN_DEBOUNCE_EN
    wait_to(290);
    btn_n = 1'b0;
    wait_to(295);
    btn_n = 1'b1;
    seq_push(320, 2'b01, "btn_long");
    wait_to(310);
    btn_n = 1'b0;
    wait_to(322);
    btn_n = 1'b1;
`else
    wait_to(290);
    btn_n = 1'b0;
    wait_to(330);
    btn_n = 1'b1;
`endif

    wait_to(360);
    check("final_stage", {5'd0, stage_rst_n}, 8'b111);
    check("final_busy", {7'd0, busy}, 8'd0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got=%0d pending expected=0 next=%s",
               exp_q.size(), exp_q[0].name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
